// File: rtl/move_commit_ctrl_if.sv
// Handshake/bus bundle between the input/render side and the move commit controller.
interface move_commit_ctrl_if;
   logic          new_game;
   logic          click_valid;
   logic [5:0]    click_pos;
   logic          click_ready;
   logic [3:0]    gen_figure;
   logic [5:0]    gen_position;
   logic [63:0]   possible_moves;
   logic [255:0]  board_flat;
   logic [5:0]    sel_pos;
   logic          sel_active;
   logic          turn;
   logic          move_done;
   logic          move_illegal;
   logic [3:0]    captured_fig;

   modport master (
      output new_game, click_valid, click_pos, possible_moves,
      input  click_ready, gen_figure, gen_position, board_flat, sel_pos,
             sel_active, turn, move_done, move_illegal, captured_fig
   );

   modport slave (
      input  new_game, click_valid, click_pos, possible_moves,
      output click_ready, gen_figure, gen_position, board_flat, sel_pos,
             sel_active, turn, move_done, move_illegal, captured_fig
   );
endinterface

// File: rtl/move_commit_ctrl.sv
// Move commit controller: owns the board register, drives the move generator,
// validates destination clicks against the captured legal-move mask and commits.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a source click of the side to move
// MASK_WAIT | generator is computing; counting down until the mask is valid
// DST_WAIT  | mask captured; waiting for destination / reselect / deselect
// COMMIT    | one cycle: write board, report capture, toggle turn
module move_commit_ctrl #(
   parameter int MASK_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   move_commit_ctrl_if.slave  io
);

   typedef enum logic [1:0] {IDLE, MASK_WAIT, DST_WAIT, COMMIT} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(MASK_LATENCY);

   state_t        state;
   logic [2:0]    cnt;
   logic [63:0]   mask_q;
   logic [5:0]    dst_q;
   logic [5:0]    sel_pos_q;
   logic          sel_active_q;
   logic [3:0]    gen_figure_q;
   logic [5:0]    gen_position_q;
   logic [255:0]  board_q;
   logic          turn_q;
   logic          move_done_q;
   logic          move_illegal_q;
   logic [3:0]    captured_q;
   logic [3:0]    click_fig;
   logic          click_own;
   logic [3:0]    moved_fig;

   function automatic logic [255:0] init_board();
      logic [255:0] b;
      logic [3:0]   back [8];
      back = '{4'd4, 4'd3, 4'd2, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4};
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[c*4 +: 4]        = back[c];
         b[(8 + c)*4 +: 4]  = 4'd1;
         b[(48 + c)*4 +: 4] = 4'd7;
         b[(56 + c)*4 +: 4] = back[c] + 4'd6;
      end
      return b;
   endfunction

   function automatic logic is_own(input logic [3:0] fig, input logic side);
      if (!side) return (fig >= 4'd1) && (fig <= 4'd6);
      return (fig >= 4'd7) && (fig <= 4'd12);
   endfunction

   // Figure under the click and whether it belongs to the side to move.
   always_comb begin
      click_fig = board_q[{io.click_pos, 2'b00} +: 4];
      click_own = is_own(click_fig, turn_q);
   end

   // Pawns reaching the last rank become queens of their own colour.
   always_comb begin
      moved_fig = gen_figure_q;
      if (gen_figure_q == 4'd1 && dst_q[5:3] == 3'd7) moved_fig = 4'd5;
      if (gen_figure_q == 4'd7 && dst_q[5:3] == 3'd0) moved_fig = 4'd11;
   end

   // Sequencing FSM with registered outputs; new_game overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= 3'd0;
         mask_q         <= '0;
         dst_q          <= 6'd0;
         sel_pos_q      <= 6'd0;
         sel_active_q   <= 1'b0;
         gen_figure_q   <= 4'd0;
         gen_position_q <= 6'd0;
         board_q        <= init_board();
         turn_q         <= 1'b0;
         move_done_q    <= 1'b0;
         move_illegal_q <= 1'b0;
         captured_q     <= 4'd0;
      end else begin
         move_done_q    <= 1'b0;
         move_illegal_q <= 1'b0;
         if (io.new_game) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            mask_q         <= '0;
            dst_q          <= 6'd0;
            sel_pos_q      <= 6'd0;
            sel_active_q   <= 1'b0;
            gen_figure_q   <= 4'd0;
            gen_position_q <= 6'd0;
            board_q        <= init_board();
            turn_q         <= 1'b0;
            captured_q     <= 4'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (io.click_valid && click_own) begin
                     sel_pos_q      <= io.click_pos;
                     gen_figure_q   <= click_fig;
                     gen_position_q <= io.click_pos;
                     sel_active_q   <= 1'b1;
                     cnt            <= CNT_LOAD;
                     state          <= MASK_WAIT;
                  end
               end
               MASK_WAIT: begin
                  // Capture on the cycle the count reaches zero.
                  if (cnt <= 3'd1) begin
                     cnt    <= 3'd0;
                     mask_q <= io.possible_moves;
                     state  <= DST_WAIT;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end
               DST_WAIT: begin
                  if (io.click_valid) begin
                     if (io.click_pos == sel_pos_q) begin
                        sel_active_q <= 1'b0;
                        state        <= IDLE;
                     end else if (click_own) begin
                        sel_pos_q      <= io.click_pos;
                        gen_figure_q   <= click_fig;
                        gen_position_q <= io.click_pos;
                        cnt            <= CNT_LOAD;
                        state          <= MASK_WAIT;
                     end else if (mask_q[io.click_pos]) begin
                        dst_q <= io.click_pos;
                        state <= COMMIT;
                     end else begin
                        move_illegal_q <= 1'b1;
                        sel_active_q   <= 1'b0;
                        state          <= IDLE;
                     end
                  end
               end
               COMMIT: begin
                  board_q[{dst_q, 2'b00} +: 4]     <= moved_fig;
                  board_q[{sel_pos_q, 2'b00} +: 4] <= 4'd0;
                  captured_q   <= board_q[{dst_q, 2'b00} +: 4];
                  move_done_q  <= 1'b1;
                  turn_q       <= ~turn_q;
                  sel_active_q <= 1'b0;
                  state        <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign io.click_ready  = (state == IDLE) || (state == DST_WAIT);
   assign io.gen_figure   = gen_figure_q;
   assign io.gen_position = gen_position_q;
   assign io.board_flat   = board_q;
   assign io.sel_pos      = sel_pos_q;
   assign io.sel_active   = sel_active_q;
   assign io.turn         = turn_q;
   assign io.move_done    = move_done_q;
   assign io.move_illegal = move_illegal_q;
   assign io.captured_fig = captured_q;

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Directed bench for move_commit_ctrl: one instance at latency 1, one at latency 3.
module tb_move_commit_ctrl;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   logic [3:0]   exp_b [64];
   logic         exp_turn;
   logic [255:0] init_flat;

   move_commit_ctrl_if ifa ();
   move_commit_ctrl_if ifb ();

   move_commit_ctrl #(.MASK_LATENCY(1)) dut  (.clk(clk), .rst_n(rst_n), .io(ifa));
   move_commit_ctrl #(.MASK_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .io(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [255:0] pack_b();
      logic [255:0] b;
      for (int i = 0; i < 64; i++) b[i*4 +: 4] = exp_b[i];
      return b;
   endfunction

   function automatic logic [3:0] sq(input logic [255:0] b, input int i);
      return b[i*4 +: 4];
   endfunction

   task automatic click_a(input int pos);
      ifa.click_valid = 1'b1;
      ifa.click_pos   = 6'(pos);
      tick();
      ifa.click_valid = 1'b0;
   endtask

   task automatic click_b(input int pos);
      ifb.click_valid = 1'b1;
      ifb.click_pos   = 6'(pos);
      tick();
      ifb.click_valid = 1'b0;
   endtask

   // Full move on the latency-1 instance with the destination clicked at the first chance.
   task automatic do_move(input string tag, input int src, input int dst);
      logic [3:0] fig;
      logic [3:0] cap;
      fig = exp_b[src];
      cap = exp_b[dst];
      ifa.possible_moves = 64'd1 << dst;
      click_a(src);
      chk({tag, ".gen_fig"}, 256'(ifa.gen_figure), 256'(fig));
      chk({tag, ".gen_pos"}, 256'(ifa.gen_position), 256'(src));
      chk({tag, ".busy"}, 256'(ifa.click_ready), 256'(1'b0));
      tick();
      click_a(dst);
      chk({tag, ".done_early"}, 256'(ifa.move_done), 256'(1'b0));
      tick();
      if (fig == 4'd1 && dst / 8 == 7) fig = 4'd5;
      if (fig == 4'd7 && dst / 8 == 0) fig = 4'd11;
      exp_b[dst] = fig;
      exp_b[src] = 4'd0;
      exp_turn   = ~exp_turn;
      chk({tag, ".done"}, 256'(ifa.move_done), 256'(1'b1));
      chk({tag, ".board"}, ifa.board_flat, pack_b());
      chk({tag, ".captured"}, 256'(ifa.captured_fig), 256'(cap));
      chk({tag, ".turn"}, 256'(ifa.turn), 256'(exp_turn));
      tick();
      chk({tag, ".done_clear"}, 256'(ifa.move_done), 256'(1'b0));
      chk({tag, ".sel_clear"}, 256'(ifa.sel_active), 256'(1'b0));
   endtask

   initial begin
      logic [3:0] row0 [8];
      passed = 0;
      total  = 0;
      row0 = '{4'd4, 4'd3, 4'd2, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4};
      for (int i = 0; i < 64; i++) exp_b[i] = 4'd0;
      for (int c = 0; c < 8; c++) begin
         exp_b[c]      = row0[c];
         exp_b[8 + c]  = 4'd1;
         exp_b[48 + c] = 4'd7;
      end
      exp_b[56] = 4'd10; exp_b[57] = 4'd9;  exp_b[58] = 4'd8;  exp_b[59] = 4'd11;
      exp_b[60] = 4'd12; exp_b[61] = 4'd8;  exp_b[62] = 4'd9;  exp_b[63] = 4'd10;
      init_flat = pack_b();
      exp_turn  = 1'b0;

      ifa.new_game = 1'b0; ifa.click_valid = 1'b0; ifa.click_pos = 6'd0; ifa.possible_moves = '0;
      ifb.new_game = 1'b0; ifb.click_valid = 1'b0; ifb.click_pos = 6'd0; ifb.possible_moves = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst.board", ifa.board_flat, init_flat);
      chk("rst.turn", 256'(ifa.turn), 256'(1'b0));
      chk("rst.ready", 256'(ifa.click_ready), 256'(1'b1));
      chk("rst.sel", 256'(ifa.sel_active), 256'(1'b0));
      chk("rst.gen", 256'({ifa.gen_figure, ifa.gen_position}), 256'(10'd0));
      chk("rst.cap", 256'(ifa.captured_fig), 256'(4'd0));

      // Wrong colour click while white to move is ignored
      click_a(52);
      chk("wrongcol.sel", 256'(ifa.sel_active), 256'(1'b0));
      chk("wrongcol.ready", 256'(ifa.click_ready), 256'(1'b1));
      chk("wrongcol.pulse", 256'({ifa.move_done, ifa.move_illegal}), 256'(2'b00));

      // e2-e4 with two-bit mask {20,28}
      ifa.possible_moves = (64'd1 << 20) | (64'd1 << 28);
      click_a(12);
      chk("e4.gen_fig", 256'(ifa.gen_figure), 256'(4'd1));
      chk("e4.gen_pos", 256'(ifa.gen_position), 256'(6'd12));
      chk("e4.sel_active", 256'(ifa.sel_active), 256'(1'b1));
      chk("e4.busy", 256'(ifa.click_ready), 256'(1'b0));
      tick();
      chk("e4.dstwait", 256'(ifa.click_ready), 256'(1'b1));
      click_a(28);
      tick();
      chk("e4.done", 256'(ifa.move_done), 256'(1'b1));
      chk("e4.sq28", 256'(sq(ifa.board_flat, 28)), 256'(4'd1));
      chk("e4.sq12", 256'(sq(ifa.board_flat, 12)), 256'(4'd0));
      chk("e4.turn", 256'(ifa.turn), 256'(1'b1));
      chk("e4.cap", 256'(ifa.captured_fig), 256'(4'd0));
      exp_b[28] = 4'd1; exp_b[12] = 4'd0; exp_turn = 1'b1;
      tick();
      chk("e4.done_clear", 256'(ifa.move_done), 256'(1'b0));

      do_move("e6", 52, 44);

      // Illegal destination
      ifa.possible_moves = (64'd1 << 19) | (64'd1 << 27);
      click_a(11);
      tick();
      click_a(35);
      chk("illegal.pulse", 256'(ifa.move_illegal), 256'(1'b1));
      chk("illegal.sel", 256'(ifa.sel_active), 256'(1'b0));
      tick();
      chk("illegal.clear", 256'(ifa.move_illegal), 256'(1'b0));
      chk("illegal.board", ifa.board_flat, pack_b());
      chk("illegal.turn", 256'(ifa.turn), 256'(1'b0));
      chk("illegal.idle", 256'(ifa.click_ready), 256'(1'b1));

      // Deselect by clicking the source again
      click_a(11);
      tick();
      click_a(11);
      chk("desel.sel", 256'(ifa.sel_active), 256'(1'b0));
      chk("desel.pulse", 256'({ifa.move_done, ifa.move_illegal}), 256'(2'b00));

      // Build the promotion position, then promote with capture
      do_move("w1", 28, 49);
      do_move("b1", 58, 42);
      do_move("w2", 11, 19);
      do_move("b2", 56, 58);
      do_move("promo", 49, 58);
      chk("promo.sq58", 256'(sq(ifa.board_flat, 58)), 256'(4'd5));
      chk("promo.cap", 256'(ifa.captured_fig), 256'(4'd10));
      chk("promo.turn", 256'(ifa.turn), 256'(1'b1));
      chk("promo.sq49", 256'(sq(ifa.board_flat, 49)), 256'(4'd0));

      // Latency 3 instance: dropped clicks during MASK_WAIT, timing, new_game
      ifb.possible_moves = 64'd1 << 28;
      click_b(12);
      chk("l3.busy0", 256'(ifb.click_ready), 256'(1'b0));
      click_b(11);
      chk("l3.ignored", 256'({ifb.sel_pos, ifb.gen_position}), 256'({6'd12, 6'd12}));
      chk("l3.busy1", 256'(ifb.click_ready), 256'(1'b0));
      tick();
      chk("l3.busy2", 256'(ifb.click_ready), 256'(1'b0));
      tick();
      chk("l3.ready", 256'(ifb.click_ready), 256'(1'b1));
      chk("l3.noqueue", 256'(ifb.sel_pos), 256'(6'd12));
      click_b(28);
      chk("l3.done_early", 256'(ifb.move_done), 256'(1'b0));
      tick();
      chk("l3.done", 256'(ifb.move_done), 256'(1'b1));
      chk("l3.turn", 256'(ifb.turn), 256'(1'b1));
      tick();
      ifb.possible_moves = 64'd1 << 44;
      click_b(52);
      repeat (3) tick();
      chk("l3.dstwait", 256'({ifb.click_ready, ifb.sel_active}), 256'(2'b11));
      ifb.new_game    = 1'b1;
      ifb.click_valid = 1'b1;
      ifb.click_pos   = 6'd44;
      tick();
      ifb.new_game    = 1'b0;
      ifb.click_valid = 1'b0;
      chk("ng.board", ifb.board_flat, init_flat);
      chk("ng.sel", 256'(ifb.sel_active), 256'(1'b0));
      chk("ng.turn", 256'(ifb.turn), 256'(1'b0));
      chk("ng.done", 256'(ifb.move_done), 256'(1'b0));
      tick();
      chk("ng.done2", 256'(ifb.move_done), 256'(1'b0));
      chk("ng.idle", 256'(ifb.click_ready), 256'(1'b1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
